// File: rtl/i2c_arb_pkg.sv
// Shared types and sizing helpers for the I2C transaction arbiter.
package i2c_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    GAP   = 3'd4
  } arb_state_t;

  // Width of a client index; never less than one bit.
  function automatic int id_w(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  // Width of a counter that runs 0 .. limit-1.
  function automatic int cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. ptr is expected to stay below NUM_REQ.
module rr_picker
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [ID_W-1:0]    ptr_in,
  output logic [ID_W-1:0]    idx_out,
  output logic               found_out
);

  int pos;

  // Scan offsets from the far end down so the nearest pending request wins.
  always_comb begin
    idx_out   = '0;
    found_out = 1'b0;
    pos       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr_in) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (req_in[pos]) begin
        idx_out   = ID_W'(pos);
        found_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between NUM_REQ clients: round-robin grant, one
// trigger per transaction, wait for the master's valid edge or a timeout,
// return the byte, then hold off for GAP_CYCLES so the bus can recover.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int GAP_CYCLES     = 1024,
  localparam int ID_W          = id_w(NUM_REQ)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ack_out,
  output logic                          rsp_valid_out,
  output logic [ID_W-1:0]               rsp_id_out,
  output logic [DATA_WIDTH-1:0]         rsp_data_out,
  output logic                          rsp_err_out,
  output logic                          busy_out,
  output logic [DATA_WIDTH-1:0]         m_address_out,
  output logic [DATA_WIDTH-1:0]         m_data_out,
  output logic                          m_trigger_out,
  input  logic [DATA_WIDTH-1:0]         m_data_in,
  input  logic                          m_valid_in
);

  localparam int TO_W  = cnt_w(TIMEOUT_CYCLES);
  localparam int GAP_W = cnt_w(GAP_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  arb_state_t             state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        cur_id_q, cur_id_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   trig_q, trig_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]  m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                   valid_q;
  logic                   completion;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_found;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_in    (req_in),
    .ptr_in    (rr_ptr_q),
    .idx_out   (pick_idx),
    .found_out (pick_found)
  );

  // Only a fresh rising edge of the master's valid level ends a transaction.
  assign completion = m_valid_in & ~valid_q;

  // Next-state and registered-output logic; all outputs are flops.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    ack_d       = '0;
    trig_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    m_addr_d    = m_addr_q;
    m_data_d    = m_data_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          cur_id_d = pick_idx;
          m_addr_d = req_addr_in[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          m_data_d = req_data_in[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          ack_d    = NUM_REQ'(1) << pick_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        trig_d   = 1'b1;
        rr_ptr_d = (cur_id_q == ID_LAST) ? '0 : cur_id_q + 1'b1;
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (completion) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_data_d  = m_data_in;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        gap_cnt_d = '0;
        state_d   = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      ack_q       <= '0;
      trig_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      m_addr_q    <= '0;
      m_data_q    <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      ack_q       <= ack_d;
      trig_q      <= trig_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      m_addr_q    <= m_addr_d;
      m_data_q    <= m_data_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      valid_q     <= m_valid_in;
    end
  end

  assign req_ack_out   = ack_q;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_id_out    = rsp_id_q;
  assign rsp_data_out  = rsp_data_q;
  assign rsp_err_out   = rsp_err_q;
  assign busy_out      = (state_q != IDLE);
  assign m_address_out = m_addr_q;
  assign m_data_out    = m_data_q;
  assign m_trigger_out = trig_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: a timestamp-based transaction model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_i2c_txn_arbiter;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int TO  = 100;
  localparam int GAP = 16;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [N-1:0]    req_in;
  logic [N*DW-1:0] req_addr_in;
  logic [N*DW-1:0] req_data_in;
  logic [N-1:0]    req_ack_out;
  logic            rsp_valid_out;
  logic [1:0]      rsp_id_out;
  logic [DW-1:0]   rsp_data_out;
  logic            rsp_err_out;
  logic            busy_out;
  logic [DW-1:0]   m_address_out;
  logic [DW-1:0]   m_data_out;
  logic            m_trigger_out;
  logic [DW-1:0]   m_data_in;
  logic            m_valid_in;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  i2c_txn_arbiter #(
    .NUM_REQ        (N),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_in        (req_in),
    .req_addr_in   (req_addr_in),
    .req_data_in   (req_data_in),
    .req_ack_out   (req_ack_out),
    .rsp_valid_out (rsp_valid_out),
    .rsp_id_out    (rsp_id_out),
    .rsp_data_out  (rsp_data_out),
    .rsp_err_out   (rsp_err_out),
    .busy_out      (busy_out),
    .m_address_out (m_address_out),
    .m_data_out    (m_data_out),
    .m_trigger_out (m_trigger_out),
    .m_data_in     (m_data_in),
    .m_valid_in    (m_valid_in)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 'h%0h, need 'h%0h", name, cyc, act, exp);
    end
  endtask

  task automatic budget_fail(input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not seen within cycle budget (cycle %0d)", what, cyc);
  endtask

  // ---------------- transaction model ----------------
  // Each transaction is a set of timestamps: ack at capture+1, trigger at
  // capture+2, response at completion+1 or trigger+TO, idle again GAP
  // cycles after the response.
  int   t_ack = -1, t_trig = -1, t_rsp = -1, t_free = 0;
  int   win = 0, next_start = 0, e_id = 0;
  bit   resolved = 1'b1, vprev = 1'b0, chk_en = 1'b0;
  logic [7:0] e_addr = '0, e_data = '0, e_rdata = '0, p_rdata = '0;
  logic e_err = 1'b0, p_err = 1'b0;

  always @(negedge clk_in) begin
    int  c;
    bit  found;
    c = cyc;
    found = 1'b0;
    if (chk_en) begin
      chk("ack", 32'(req_ack_out), (c == t_ack) ? (32'd1 << win) : 32'd0);
      chk("trigger", 32'(m_trigger_out), 32'(c == t_trig));
      chk("rsp_valid", 32'(rsp_valid_out), 32'(c == t_rsp));
      chk("busy", 32'(busy_out), 32'(t_ack >= 0 && c >= t_ack && c < t_free));
      chk("m_address", 32'(m_address_out), 32'(e_addr));
      chk("m_data", 32'(m_data_out), 32'(e_data));
      chk("rsp_id", 32'(rsp_id_out), 32'(e_id));
      chk("rsp_data", 32'(rsp_data_out), 32'(e_rdata));
      chk("rsp_err", 32'(rsp_err_out), 32'(e_err));
    end
    if (rsp_valid_out === 1'b1)
      $display("txn cycle=%0d id=%0d data=%02h err=%0d", c, rsp_id_out, rsp_data_out, rsp_err_out);
    if (rst_in) begin
      t_ack = -1; t_trig = -1; t_rsp = -1; t_free = c + 1;
      resolved = 1'b1; next_start = 0; vprev = 1'b0;
      e_addr = '0; e_data = '0; e_rdata = '0; e_err = 1'b0; e_id = 0; win = 0;
      chk_en = 1'b1;
    end else begin
      if (c >= t_free && req_in != '0) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req_in[(next_start + k) % N]) begin
            win = (next_start + k) % N;
            found = 1'b1;
          end
        end
        t_ack = c + 1; t_trig = c + 2; t_rsp = t_trig + TO; t_free = t_rsp + GAP + 1;
        resolved = 1'b0; p_rdata = '0; p_err = 1'b1;
        e_addr = req_addr_in[win*DW +: DW];
        e_data = req_data_in[win*DW +: DW];
        next_start = (win + 1) % N;
      end else if (!resolved && t_trig >= 0 && c >= t_trig && c < t_rsp && m_valid_in && !vprev) begin
        resolved = 1'b1; t_rsp = c + 1; t_free = t_rsp + GAP + 1;
        p_rdata = m_data_in; p_err = 1'b0;
      end
      if (t_rsp >= 0 && c + 1 == t_rsp) begin
        e_rdata = p_rdata; e_err = p_err; e_id = win; resolved = 1'b1;
      end
      vprev = m_valid_in;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ack(output int idx, output int acyc);
    bit seen;
    seen = 1'b0; idx = -1; acyc = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_in);
      if (req_ack_out != '0) begin
        seen = 1'b1;
        acyc = cyc;
        for (int b = 0; b < N; b++) if (req_ack_out[b]) idx = b;
      end
    end
    if (!seen) budget_fail("ack_wait");
  endtask

  task automatic wait_trig(output int tcyc);
    bit seen;
    seen = 1'b0; tcyc = -1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_in);
      if (m_trigger_out === 1'b1) begin seen = 1'b1; tcyc = cyc; end
    end
    if (!seen) budget_fail("trigger_wait");
  endtask

  task automatic wait_rsp(input int budget, output int rcyc);
    bit seen;
    seen = 1'b0; rcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_in);
      if (rsp_valid_out === 1'b1) begin seen = 1'b1; rcyc = cyc; end
    end
    if (!seen) budget_fail("rsp_wait");
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_in);
      if (busy_out === 1'b0) seen = 1'b1;
    end
    if (!seen) budget_fail("idle_wait");
  endtask

  // Stub master: raise valid with a byte k cycles after the trigger cycle.
  task automatic stub_raise(input int k, input logic [7:0] d);
    repeat (k) @(posedge clk_in);
    #1;
    m_data_in  = d;
    m_valid_in = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int idx, a, w, r, t0, c1;
    int grants[6];
    rst_in = 1'b1; req_in = '0; req_addr_in = '0; req_data_in = '0;
    m_data_in = '0; m_valid_in = 1'b0;
    repeat (3) tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("reset_ack", 32'(req_ack_out), 32'd0);
    chk("reset_busy", 32'(busy_out), 32'd0);
    chk("reset_addr", 32'(m_address_out), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_out), 32'd0);

    // Single request from client 1.
    tick();
    req_addr_in[1*DW +: DW] = 8'h3C;
    req_data_in[1*DW +: DW] = 8'h0F;
    req_in = 3'b010;
    t0 = cyc;
    wait_ack(idx, a);
    chk("single_ack_cycle", 32'(a), 32'(t0 + 1));
    chk("single_ack_vec", 32'(req_ack_out), 32'b010);
    tick(); req_in = '0;
    wait_trig(w);
    chk("single_trig_cycle", 32'(w), 32'(t0 + 2));
    chk("single_trig_addr", 32'(m_address_out), 32'h3C);
    chk("single_trig_data", 32'(m_data_out), 32'h0F);
    stub_raise(20, 8'hA5);
    wait_rsp(40, r);
    chk("single_rsp_cycle", 32'(r), 32'(w + 21));
    chk("single_rsp_id", 32'(rsp_id_out), 32'd1);
    chk("single_rsp_data", 32'(rsp_data_out), 32'hA5);
    chk("single_rsp_err", 32'(rsp_err_out), 32'd0);
    tick(); m_valid_in = 1'b0;
    wait_idle();

    // Round robin from a fresh reset with all clients requesting.
    tick(); rst_in = 1'b1;
    tick(); rst_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr_in[i*DW +: DW] = 8'(8'h10 + i);
      req_data_in[i*DW +: DW] = 8'(8'h20 + i);
    end
    req_in = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_ack(idx, a);
      grants[i] = idx;
      tick();
      if (idx >= 0) req_in[idx] = 1'b0;
      wait_trig(w);
      stub_raise(5, 8'(8'h40 + i));
      wait_rsp(20, r);
      tick(); m_valid_in = 1'b0;
      if (i < 5 && idx >= 0) req_in[idx] = 1'b1;
      else req_in = '0;
    end
    for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 3));
    wait_idle();

    // Timeout: master never answers.
    tick(); req_in = 3'b001;
    wait_ack(idx, a);
    tick(); req_in = '0;
    wait_trig(w);
    wait_rsp(130, r);
    chk("timeout_rsp_cycle", 32'(r), 32'(w + 100));
    chk("timeout_err", 32'(rsp_err_out), 32'd1);
    chk("timeout_data", 32'(rsp_data_out), 32'd0);
    chk("timeout_id", 32'(rsp_id_out), 32'd0);
    tick(); req_in = 3'b001;
    wait_ack(idx, a);
    chk("gap_next_ack_cycle", 32'(a), 32'(r + GAP + 2));
    tick(); req_in = '0;
    wait_trig(w);
    stub_raise(3, 8'h11);
    wait_rsp(20, r);
    tick(); m_valid_in = 1'b0;
    wait_idle();

    // Stale valid: level already high at trigger must not complete.
    tick(); m_data_in = 8'h77; m_valid_in = 1'b1; req_in = 3'b100;
    wait_ack(idx, a);
    tick(); req_in = '0;
    wait_trig(w);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      chk($sformatf("stale_no_rsp%0d", i), 32'(rsp_valid_out), 32'd0);
    end
    tick(); m_valid_in = 1'b0;
    tick(); m_valid_in = 1'b1; m_data_in = 8'h5A; c1 = cyc;
    wait_rsp(20, r);
    chk("stale_rsp_cycle", 32'(r), 32'(c1 + 1));
    chk("stale_rsp_data", 32'(rsp_data_out), 32'h5A);
    chk("stale_rsp_err", 32'(rsp_err_out), 32'd0);
    chk("stale_rsp_id", 32'(rsp_id_out), 32'd2);
    tick(); m_valid_in = 1'b0;
    wait_idle();

    // Completion edge on the very cycle the timeout would fire.
    tick(); req_addr_in[1*DW +: DW] = 8'h55; req_in = 3'b010;
    wait_ack(idx, a);
    tick(); req_in = '0;
    wait_trig(w);
    stub_raise(99, 8'hC3);
    wait_rsp(10, r);
    chk("coincide_rsp_cycle", 32'(r), 32'(w + 100));
    chk("coincide_err", 32'(rsp_err_out), 32'd0);
    chk("coincide_data", 32'(rsp_data_out), 32'hC3);
    tick(); m_valid_in = 1'b0;
    wait_idle();

    // Reset ten cycles into WAIT: silent abandon, pointer back to 0.
    tick(); req_in = 3'b010;
    wait_ack(idx, a);
    tick(); req_in = '0;
    wait_trig(w);
    repeat (9) @(negedge clk_in);
    tick(); rst_in = 1'b1;
    tick(); rst_in = 1'b0; req_in = 3'b110;
    @(negedge clk_in);
    chk("rstwait_busy", 32'(busy_out), 32'd0);
    chk("rstwait_ack", 32'(req_ack_out), 32'd0);
    chk("rstwait_trig", 32'(m_trigger_out), 32'd0);
    chk("rstwait_rsp_valid", 32'(rsp_valid_out), 32'd0);
    chk("rstwait_rsp_data", 32'(rsp_data_out), 32'd0);
    chk("rstwait_rsp_id", 32'(rsp_id_out), 32'd0);
    chk("rstwait_rsp_err", 32'(rsp_err_out), 32'd0);
    chk("rstwait_addr", 32'(m_address_out), 32'd0);
    chk("rstwait_data", 32'(m_data_out), 32'd0);
    wait_ack(idx, a);
    chk("rstwait_next_grant", 32'(idx), 32'd1);
    tick(); req_in = '0;
    wait_trig(w);
    stub_raise(2, 8'h99);
    wait_rsp(10, r);
    tick(); m_valid_in = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
